// File: rtl/io_map_pkg.sv
// rtl/io_map_pkg.sv - register map, status bit positions and address decode for io_bank
package io_map_pkg;

  // Byte offsets within the 0x80000000-0x800000FF window
  localparam logic [7:0] OFF_GPIO_OUT   = 8'h00;
  localparam logic [7:0] OFF_GPIO_IN    = 8'h04;
  localparam logic [7:0] OFF_CYCLE      = 8'h08;
  localparam logic [7:0] OFF_TIMER_CMP  = 8'h0C;
  localparam logic [7:0] OFF_TIMER_STAT = 8'h10;
  localparam logic [7:0] OFF_TX_DATA    = 8'h14;
  localparam logic [7:0] OFF_TX_STAT    = 8'h18;

  // TIMER_STAT bit positions
  localparam int TSTAT_MATCH_BIT = 0;
  localparam int TSTAT_EN_BIT    = 1;
  localparam int TSTAT_OVF_BIT   = 2;

  // TX_STAT bit positions; count occupies TX_DEPTH_LOG+1 bits from COUNT_LSB
  localparam int TXSTAT_FULL_BIT  = 0;
  localparam int TXSTAT_EMPTY_BIT = 1;
  localparam int TXSTAT_COUNT_LSB = 2;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_GPIO_OUT,
    SEL_GPIO_IN,
    SEL_CYCLE,
    SEL_TIMER_CMP,
    SEL_TIMER_STAT,
    SEL_TX_DATA,
    SEL_TX_STAT
  } reg_sel_e;

  // Word index (addr[7:2]) to register select; anything unmapped is SEL_NONE
  function automatic reg_sel_e decode_word(input logic [5:0] word);
    reg_sel_e sel;
    case (word)
      OFF_GPIO_OUT[7:2]:   sel = SEL_GPIO_OUT;
      OFF_GPIO_IN[7:2]:    sel = SEL_GPIO_IN;
      OFF_CYCLE[7:2]:      sel = SEL_CYCLE;
      OFF_TIMER_CMP[7:2]:  sel = SEL_TIMER_CMP;
      OFF_TIMER_STAT[7:2]: sel = SEL_TIMER_STAT;
      OFF_TX_DATA[7:2]:    sel = SEL_TX_DATA;
      OFF_TX_STAT[7:2]:    sel = SEL_TX_STAT;
      default:             sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/io_tx_fifo.sv
// rtl/io_tx_fifo.sv - byte-wide TX FIFO with occupancy count; storage is not reset
module io_tx_fifo #(
  parameter int TX_DEPTH     = 4,
  parameter int TX_DEPTH_LOG = 2
) (
  input  logic                    clk,
  input  logic                    resetb,
  input  logic                    push,
  input  logic [7:0]              push_data,
  input  logic                    pop,
  output logic [7:0]              head,
  output logic [TX_DEPTH_LOG:0]   count,
  output logic                    full,
  output logic                    empty
);

  localparam int CNT_W = TX_DEPTH_LOG + 1;

  logic [7:0]              mem_q [TX_DEPTH];
  logic [TX_DEPTH_LOG-1:0] wr_ptr_q, wr_ptr_d;
  logic [TX_DEPTH_LOG-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;

  // Pointers wrap naturally at TX_DEPTH since the depth is a power of two
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + TX_DEPTH_LOG'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + TX_DEPTH_LOG'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count state; reset empties the queue
  always_ff @(posedge clk) begin
    if (!resetb) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; a push coinciding with reset is discarded
  always_ff @(posedge clk) begin
    if (push && resetb) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  // Count never exceeds TX_DEPTH, so its MSB alone marks full
  assign full  = count_q[TX_DEPTH_LOG];
  assign empty = (count_q == '0);

endmodule

// File: rtl/io_bank.sv
// rtl/io_bank.sv - memory-mapped GPIO, free-running cycle counter, compare timer and TX FIFO
module io_bank
  import io_map_pkg::*;
#(
  parameter int TX_DEPTH     = 4,
  parameter int TX_DEPTH_LOG = 2
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic [7:0]  io_addr,
  input  logic        io_en,
  input  logic        io_we,
  input  logic [31:0] io_data_write,
  output logic [31:0] io_data_read,
  input  logic [31:0] gpio_in,
  output logic [31:0] gpio_out,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        timer_irq
);

  localparam int CNT_W = TX_DEPTH_LOG + 1;

  reg_sel_e sel;
  logic     acc_wr, acc_rd;

  logic [31:0] gpio_out_q, gpio_out_d;
  logic [31:0] sync1_q, sync2_q;
  logic [31:0] cycle_q;
  logic [31:0] cmp_q, cmp_d;
  logic        match_q, match_d;
  logic        en_q, en_d;
  logic        ovf_q, ovf_d;
  logic        irq_q;

  logic             tx_wr, match_set, ovf_set, stat_wr;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]       fifo_head;
  logic [CNT_W-1:0] fifo_count;

  // Byte lanes are pre-shifted upstream, so the low address bits carry nothing
  logic unused_addr;
  assign unused_addr = ^io_addr[1:0];

  assign sel    = decode_word(io_addr[7:2]);
  assign acc_wr = io_en & io_we;
  assign acc_rd = io_en & ~io_we;

  assign tx_wr     = acc_wr && (sel == SEL_TX_DATA);
  assign stat_wr   = acc_wr && (sel == SEL_TIMER_STAT);
  assign fifo_pop  = ~fifo_empty & tx_ready;
  // A full FIFO still takes the byte when the head leaves in the same cycle
  assign fifo_push = tx_wr & (~fifo_full | fifo_pop);
  assign ovf_set   = tx_wr & fifo_full & ~fifo_pop;
  // Compare against the registered CMP/EN so a same-cycle write does not affect it
  assign match_set = en_q && (cycle_q == cmp_q);

  io_tx_fifo #(
    .TX_DEPTH     (TX_DEPTH),
    .TX_DEPTH_LOG (TX_DEPTH_LOG)
  ) u_tx_fifo (
    .clk       (clk),
    .resetb    (resetb),
    .push      (fifo_push),
    .push_data (io_data_write[7:0]),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Next-state for writable registers; sticky bits favour set over W1C clear
  always_comb begin
    gpio_out_d = gpio_out_q;
    cmp_d      = cmp_q;
    en_d       = en_q;
    if (acc_wr && sel == SEL_GPIO_OUT)  gpio_out_d = io_data_write;
    if (acc_wr && sel == SEL_TIMER_CMP) cmp_d      = io_data_write;
    if (stat_wr)                        en_d       = io_data_write[TSTAT_EN_BIT];
    match_d = match_set | (match_q & ~(stat_wr & io_data_write[TSTAT_MATCH_BIT]));
    ovf_d   = ovf_set   | (ovf_q   & ~(stat_wr & io_data_write[TSTAT_OVF_BIT]));
  end

  // Register state, input synchroniser and cycle counter
  always_ff @(posedge clk) begin
    if (!resetb) begin
      gpio_out_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      cycle_q    <= '0;
      cmp_q      <= '0;
      match_q    <= 1'b0;
      en_q       <= 1'b0;
      ovf_q      <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      gpio_out_q <= gpio_out_d;
      sync1_q    <= gpio_in;
      sync2_q    <= sync1_q;
      cycle_q    <= cycle_q + 32'd1;
      cmp_q      <= cmp_d;
      match_q    <= match_d;
      en_q       <= en_d;
      ovf_q      <= ovf_d;
      irq_q      <= match_q & en_q;
    end
  end

  // Side-effect-free read mux; idle, write and unmapped/write-only reads give 0
  always_comb begin
    io_data_read = '0;
    if (acc_rd) begin
      case (sel)
        SEL_GPIO_OUT:  io_data_read = gpio_out_q;
        SEL_GPIO_IN:   io_data_read = sync2_q;
        SEL_CYCLE:     io_data_read = cycle_q;
        SEL_TIMER_CMP: io_data_read = cmp_q;
        SEL_TIMER_STAT: begin
          io_data_read[TSTAT_MATCH_BIT] = match_q;
          io_data_read[TSTAT_EN_BIT]    = en_q;
          io_data_read[TSTAT_OVF_BIT]   = ovf_q;
        end
        SEL_TX_STAT: begin
          io_data_read[TXSTAT_FULL_BIT]              = fifo_full;
          io_data_read[TXSTAT_EMPTY_BIT]             = fifo_empty;
          io_data_read[TXSTAT_COUNT_LSB +: CNT_W]    = fifo_count;
        end
        default:       io_data_read = '0;
      endcase
    end
  end

  assign gpio_out  = gpio_out_q;
  assign tx_data   = fifo_head;
  assign tx_valid  = ~fifo_empty;
  assign timer_irq = irq_q;

endmodule

// File: tb/tb_io_bank.sv
// tb/tb_io_bank.sv - directed self-checking bench for io_bank
module tb_io_bank;
  import io_map_pkg::*;

  logic        clk;
  logic        resetb;
  logic [7:0]  io_addr;
  logic        io_en;
  logic        io_we;
  logic [31:0] io_data_write;
  logic [31:0] io_data_read;
  logic [31:0] gpio_in;
  logic [31:0] gpio_out;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        timer_irq;

  int vectors     = 0;
  int miscompares = 0;

  io_bank #(.TX_DEPTH(4), .TX_DEPTH_LOG(2)) dut (
    .clk           (clk),
    .resetb        (resetb),
    .io_addr       (io_addr),
    .io_en         (io_en),
    .io_we         (io_we),
    .io_data_write (io_data_write),
    .io_data_read  (io_data_read),
    .gpio_in       (gpio_in),
    .gpio_out      (gpio_out),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .timer_irq     (timer_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    io_addr = a; io_data_write = d; io_en = 1'b1; io_we = 1'b1;
    tick();
    io_en = 1'b0; io_we = 1'b0;
  endtask

  task automatic chk_rd(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] d;
    io_addr = a; io_en = 1'b1; io_we = 1'b0;
    #1;
    d = io_data_read;
    io_en = 1'b0;
    check(tag, d, exp);
  endtask

  initial begin
    resetb = 1'b0; io_addr = '0; io_en = 1'b0; io_we = 1'b0;
    io_data_write = '0; gpio_in = '0; tx_ready = 1'b0;
    repeat (3) tick();
    resetb = 1'b1;

    // Reset state (CYCLE = 0)
    check("rst_gpio_out", gpio_out, 32'h0);
    check("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
    check("rst_irq", {31'b0, timer_irq}, 32'h0);
    chk_rd("rst_tx_stat", OFF_TX_STAT, 32'h2);
    chk_rd("rst_timer_stat", OFF_TIMER_STAT, 32'h0);
    chk_rd("rst_cycle", OFF_CYCLE, 32'd0);
    check("idle_read_zero", io_data_read, 32'h0);

    // Timer: CMP=20, EN at CYCLE 5
    wr(OFF_TIMER_CMP, 32'd20);                 // C=1
    repeat (4) tick();                         // C=5
    chk_rd("cycle_5", OFF_CYCLE, 32'd5);
    wr(OFF_TIMER_STAT, 32'h2);                 // C=6
    chk_rd("cmp_rb", OFF_TIMER_CMP, 32'd20);
    repeat (14) tick();                        // C=20
    chk_rd("cycle_20", OFF_CYCLE, 32'd20);
    check("irq_before", {31'b0, timer_irq}, 32'h0);
    tick();                                    // C=21, MATCH set
    check("irq_one_edge", {31'b0, timer_irq}, 32'h0);
    chk_rd("stat_match", OFF_TIMER_STAT, 32'h3);
    tick();                                    // C=22
    check("irq_two_edges", {31'b0, timer_irq}, 32'h1);
    wr(OFF_TIMER_CMP, 32'd25);                 // C=23
    repeat (2) tick();                         // C=25
    chk_rd("cycle_25", OFF_CYCLE, 32'd25);
    wr(OFF_TIMER_STAT, 32'h3);                 // W1C with new match -> C=26
    chk_rd("w1c_vs_set", OFF_TIMER_STAT, 32'h3);
    wr(OFF_TIMER_STAT, 32'h3);                 // plain W1C -> C=27
    chk_rd("w1c_clear", OFF_TIMER_STAT, 32'h2);
    tick();                                    // C=28
    check("irq_cleared", {31'b0, timer_irq}, 32'h0);
    wr(OFF_TIMER_STAT, 32'h0);
    chk_rd("timer_off", OFF_TIMER_STAT, 32'h0);

    // GPIO_OUT write/readback and ignored writes
    wr(OFF_GPIO_OUT, 32'hDEADBEEF);
    check("gpio_out_pin", gpio_out, 32'hDEADBEEF);
    chk_rd("gpio_out_rd", OFF_GPIO_OUT, 32'hDEADBEEF);
    wr(8'h40, 32'h12345678);
    wr(OFF_TX_STAT, 32'hFFFFFFFF);
    check("undecoded_wr", gpio_out, 32'hDEADBEEF);
    chk_rd("ro_wr_ignored", OFF_TX_STAT, 32'h2);
    chk_rd("lane_bits_ignored", 8'h03, 32'hDEADBEEF);

    // TX FIFO fill and overflow
    tx_ready = 1'b0;
    wr(OFF_TX_DATA, 32'h41);
    check("tx_valid_after_push", {31'b0, tx_valid}, 32'h1);
    check("tx_head_41", {24'b0, tx_data}, 32'h41);
    wr(OFF_TX_DATA, 32'h42);
    wr(OFF_TX_DATA, 32'h43);
    wr(OFF_TX_DATA, 32'h44);
    wr(OFF_TX_DATA, 32'h45);
    chk_rd("tx_stat_full", OFF_TX_STAT, 32'h11);
    chk_rd("ovf_set", OFF_TIMER_STAT, 32'h4);
    chk_rd("tx_data_wo_rd", OFF_TX_DATA, 32'h0);
    tick();
    check("tx_head_held", {24'b0, tx_data}, 32'h41);
    tx_ready = 1'b1;
    check("drain_41", {24'b0, tx_data}, 32'h41); tick();
    check("drain_42", {24'b0, tx_data}, 32'h42); tick();
    check("drain_43", {24'b0, tx_data}, 32'h43); tick();
    check("drain_44", {24'b0, tx_data}, 32'h44); tick();
    check("drained_empty", {31'b0, tx_valid}, 32'h0);
    tx_ready = 1'b0;

    // Full FIFO: push with concurrent pop is accepted
    wr(OFF_TIMER_STAT, 32'h4);
    chk_rd("ovf_cleared", OFF_TIMER_STAT, 32'h0);
    wr(OFF_TX_DATA, 32'h61);
    wr(OFF_TX_DATA, 32'h62);
    wr(OFF_TX_DATA, 32'h63);
    wr(OFF_TX_DATA, 32'h64);
    tx_ready = 1'b1;
    wr(OFF_TX_DATA, 32'h55);
    tx_ready = 1'b0;
    chk_rd("push_pop_count", OFF_TX_STAT, 32'h11);
    chk_rd("ovf_unchanged", OFF_TIMER_STAT, 32'h0);
    check("head_after_pp", {24'b0, tx_data}, 32'h62);
    tx_ready = 1'b1;
    tick();
    check("tail_63", {24'b0, tx_data}, 32'h63); tick();
    check("tail_64", {24'b0, tx_data}, 32'h64); tick();
    check("tail_55", {24'b0, tx_data}, 32'h55); tick();
    check("tail_empty", {31'b0, tx_valid}, 32'h0);
    tx_ready = 1'b0;

    // GPIO input synchroniser latency
    gpio_in = 32'hA5A5A5A5;
    chk_rd("gpio_in_0e", OFF_GPIO_IN, 32'h0);
    tick();
    chk_rd("gpio_in_1e", OFF_GPIO_IN, 32'h0);
    tick();
    chk_rd("gpio_in_2e", OFF_GPIO_IN, 32'hA5A5A5A5);
    wr(OFF_GPIO_IN, 32'h0);
    chk_rd("gpio_in_ro", OFF_GPIO_IN, 32'hA5A5A5A5);
    chk_rd("undecoded_rd", 8'h40, 32'h0);

    // Reset mid-stream beats a concurrent write and clears the FIFO
    wr(OFF_TX_DATA, 32'h77);
    check("pre_rst_valid", {31'b0, tx_valid}, 32'h1);
    resetb = 1'b0;
    io_addr = OFF_GPIO_OUT; io_data_write = 32'h1234; io_en = 1'b1; io_we = 1'b1;
    tick();
    io_en = 1'b0; io_we = 1'b0;
    resetb = 1'b1;
    check("mid_rst_tx_valid", {31'b0, tx_valid}, 32'h0);
    check("mid_rst_gpio_out", gpio_out, 32'h0);
    chk_rd("mid_rst_cycle", OFF_CYCLE, 32'h0);
    chk_rd("mid_rst_gpio_in", OFF_GPIO_IN, 32'h0);
    chk_rd("mid_rst_tx_stat", OFF_TX_STAT, 32'h2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
